// File: rtl/piso_stream_serializer.sv
// ---------------------------------------------------------------------------
// piso_stream_serializer
//
// Parallel-in / serial-out stream serializer. A parallel word is accepted over
// a valid/ready handshake together with a chunk count and a frame tag. It is
// then emitted as SHIFT_AMOUNT-bit chunks over a second valid/ready handshake.
// The last chunk of each word is flagged, and so is the last chunk of a frame.
// A new word can be accepted in the same cycle as the final chunk of the
// previous one, so back-to-back words stream with no bubble.
//
// State table
//   state  | meaning
//   IDLE   | no word held; s_ready_o high, m_valid_o low
//   ACTIVE | word held in sr_q; rem_q chunks still to emit (m_valid_o high)
//
// Ports
//   clk_i           clock, rising edge
//   rst_ni          synchronous reset, active low
//   s_valid_i       input word valid
//   s_ready_o       input word ready
//   s_data_i        parallel word [PARALLEL_DATA_BITS]
//   s_len_i         chunk count: 0 means NUM_CHUNKS, values above are clamped
//   s_last_i        word closes a frame
//   abort_i         discard the word in flight
//   m_valid_o       output chunk valid
//   m_ready_i       output chunk ready
//   m_data_o        current chunk [SHIFT_AMOUNT]
//   m_last_o        current chunk is the last of its word
//   m_frame_last_o  current chunk is the last of its frame
//   busy_o          a word is held
// ---------------------------------------------------------------------------
module piso_stream_serializer #(
    parameter int    PARALLEL_DATA_BITS = 512,
    parameter int    SHIFT_AMOUNT       = 8,
    parameter string DIRECTION          = "RIGHT",
    parameter int    NUM_CHUNKS         = PARALLEL_DATA_BITS / SHIFT_AMOUNT,
    parameter int    CNT_W              = $clog2(NUM_CHUNKS + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic [PARALLEL_DATA_BITS-1:0] s_data_i,
    input  logic [CNT_W-1:0]              s_len_i,
    input  logic                          s_last_i,
    input  logic                          abort_i,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [SHIFT_AMOUNT-1:0]       m_data_o,
    output logic                          m_last_o,
    output logic                          m_frame_last_o,
    output logic                          busy_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] NUM_CHUNKS_C = CNT_W'(NUM_CHUNKS);
    localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);
    localparam bit               EMIT_LEFT    = (DIRECTION == "LEFT");

    if ((PARALLEL_DATA_BITS % SHIFT_AMOUNT) != 0) begin : g_bad_cfg
        $error("PARALLEL_DATA_BITS must be a multiple of SHIFT_AMOUNT");
    end

    state_e                        state_q, state_d;
    logic [PARALLEL_DATA_BITS-1:0] sr_q, sr_d;
    logic [PARALLEL_DATA_BITS-1:0] sr_shifted;
    logic [CNT_W-1:0]              rem_q, rem_d;
    logic [CNT_W-1:0]              len_dec;
    logic                          flast_q, flast_d;
    logic                          vld_q;

    logic out_fire;
    logic in_fire;
    logic word_done;
    logic abort_act;

    assign vld_q = (state_q == ACTIVE);

    // The emit end of the shift register faces the output; chunks move toward
    // it and the vacated end is zero-filled.
    if (EMIT_LEFT) begin : g_left
        assign m_data_o   = sr_q[PARALLEL_DATA_BITS-1 -: SHIFT_AMOUNT];
        assign sr_shifted = sr_q << SHIFT_AMOUNT;
    end else begin : g_right
        assign m_data_o   = sr_q[0 +: SHIFT_AMOUNT];
        assign sr_shifted = sr_q >> SHIFT_AMOUNT;
    end

    assign m_valid_o      = vld_q;
    assign busy_o         = vld_q;
    assign m_last_o       = vld_q & (rem_q == ONE_C);
    assign m_frame_last_o = m_last_o & flast_q;

    assign out_fire  = vld_q & m_ready_i;
    assign word_done = out_fire & m_last_o;
    assign abort_act = abort_i & vld_q;

    // Ready is combinational from m_ready_i so the next word can load in the
    // very cycle the final chunk leaves. An abort blocks that overlap; in IDLE
    // the abort has nothing to discard and leaves acceptance untouched.
    assign s_ready_o = ~vld_q | (word_done & ~abort_i);
    assign in_fire   = s_valid_i & s_ready_o;

    always_comb begin
        len_dec = s_len_i;
        if ((s_len_i == '0) || (s_len_i > NUM_CHUNKS_C)) begin
            len_dec = NUM_CHUNKS_C;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        rem_d   = rem_q;
        flast_d = flast_q;

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d = ACTIVE;
                    sr_d    = s_data_i;
                    rem_d   = len_dec;
                    flast_d = s_last_i;
                end
            end
            ACTIVE: begin
                if (abort_act) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (in_fire) begin
                    // Only reachable while the last chunk fires: reload.
                    state_d = ACTIVE;
                    sr_d    = s_data_i;
                    rem_d   = len_dec;
                    flast_d = s_last_i;
                end else if (word_done) begin
                    // sr_q is left as is; m_data_o is don't-care while idle.
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (out_fire) begin
                    sr_d  = sr_shifted;
                    rem_d = rem_q - ONE_C;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sr_q    <= '0;
            rem_q   <= '0;
            flast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            rem_q   <= rem_d;
            flast_q <= flast_d;
        end
    end

endmodule

// File: tb/tb_piso_stream_serializer.sv
module tb_piso_stream_serializer;

    localparam int PDB = 32;
    localparam int SA  = 8;
    localparam int NC  = PDB / SA;
    localparam int CW  = $clog2(NC + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          s_valid_i;
    logic [PDB-1:0] s_data_i;
    logic [CW-1:0] s_len_i;
    logic          s_last_i;
    logic          abort_i;
    logic          m_ready_i;

    logic          r_s_ready, r_m_valid, r_m_last, r_m_flast, r_busy;
    logic [SA-1:0] r_m_data;
    logic          l_s_ready, l_m_valid, l_m_last, l_m_flast, l_busy;
    logic [SA-1:0] l_m_data;

    always #5 clk_i = ~clk_i;

    piso_stream_serializer #(
        .PARALLEL_DATA_BITS(PDB), .SHIFT_AMOUNT(SA), .DIRECTION("RIGHT")
    ) u_dut_r (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_valid_i(s_valid_i), .s_ready_o(r_s_ready), .s_data_i(s_data_i),
        .s_len_i(s_len_i), .s_last_i(s_last_i), .abort_i(abort_i),
        .m_valid_o(r_m_valid), .m_ready_i(m_ready_i), .m_data_o(r_m_data),
        .m_last_o(r_m_last), .m_frame_last_o(r_m_flast), .busy_o(r_busy)
    );

    piso_stream_serializer #(
        .PARALLEL_DATA_BITS(PDB), .SHIFT_AMOUNT(SA), .DIRECTION("LEFT")
    ) u_dut_l (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_valid_i(s_valid_i), .s_ready_o(l_s_ready), .s_data_i(s_data_i),
        .s_len_i(s_len_i), .s_last_i(s_last_i), .abort_i(abort_i),
        .m_valid_o(l_m_valid), .m_ready_i(m_ready_i), .m_data_o(l_m_data),
        .m_last_o(l_m_last), .m_frame_last_o(l_m_flast), .busy_o(l_busy)
    );

    // Reference model: the chunks still owed for the held word, in emit order.
    typedef struct {
        logic [SA-1:0] dr;
        logic [SA-1:0] dl;
        logic          flast;
    } chunk_t;

    chunk_t q[$];
    bit     exp_zero = 1'b1;
    bit     acc;
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [PDB-1:0] d, input logic [CW-1:0] len,
                        input logic last, input logic rdy, input logic ab, input logic rstn);
        bit e_valid, e_last, e_flast, e_ready;
        int n;
        @(negedge clk_i);
        s_valid_i = v;
        s_data_i  = d;
        s_len_i   = len;
        s_last_i  = last;
        m_ready_i = rdy;
        abort_i   = ab;
        rst_ni    = rstn;
        #1;
        e_valid = (q.size() != 0);
        e_last  = (q.size() == 1);
        e_flast = e_last && q[0].flast;
        e_ready = e_valid ? (rdy && e_last && !ab) : 1'b1;

        check("r_m_valid", r_m_valid, e_valid);
        check("l_m_valid", l_m_valid, e_valid);
        check("r_busy", r_busy, e_valid);
        check("l_busy", l_busy, e_valid);
        check("r_m_last", r_m_last, e_last);
        check("l_m_last", l_m_last, e_last);
        check("r_m_frame_last", r_m_flast, e_flast);
        check("l_m_frame_last", l_m_flast, e_flast);
        check("r_s_ready", r_s_ready, e_ready);
        check("l_s_ready", l_s_ready, e_ready);
        if (e_valid) begin
            check("r_m_data", r_m_data, q[0].dr);
            check("l_m_data", l_m_data, q[0].dl);
        end else if (exp_zero) begin
            check("r_m_data_zero", r_m_data, 0);
            check("l_m_data_zero", l_m_data, 0);
        end

        @(posedge clk_i);
        acc = 1'b0;
        if (!rstn) begin
            q.delete();
            exp_zero = 1'b1;
        end else if (ab && e_valid) begin
            q.delete();
        end else begin
            if (e_valid && rdy) void'(q.pop_front());
            if (v && e_ready) begin
                acc = 1'b1;
                exp_zero = 1'b0;
                n = (len == 0 || len > NC) ? NC : int'(len);
                for (int i = 0; i < n; i++) begin
                    chunk_t c;
                    c.dr    = d[SA*i +: SA];
                    c.dl    = d[SA*(NC-1-i) +: SA];
                    c.flast = last;
                    q.push_back(c);
                end
            end
        end
    endtask

    task automatic idle(input logic rdy, input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, '0, '0, 1'b0, rdy, 1'b0, 1'b1);
    endtask

    task automatic send(input logic [PDB-1:0] d, input logic [CW-1:0] len, input logic last);
        int k = 0;
        acc = 1'b0;
        while (!acc && k < 20) begin
            step(1'b1, d, len, last, 1'b1, 1'b0, 1'b1);
            k++;
        end
        check("send_accept", acc, 1'b1);
    endtask

    initial begin
        s_valid_i = 1'b0; s_data_i = '0; s_len_i = '0; s_last_i = 1'b0;
        abort_i = 1'b0; m_ready_i = 1'b0; rst_ni = 1'b0;

        // Reset state
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 2);

        // Full word, frame last, both directions
        send(32'h44332211, 3'd0, 1'b1);
        idle(1'b1, 6);

        // Truncated word
        send(32'h44332211, 3'd2, 1'b1);
        idle(1'b1, 4);

        // Back-to-back words, no bubble
        send(32'hA3A2A1A0, 3'd0, 1'b0);
        send(32'hB3B2B1B0, 3'd0, 1'b1);
        idle(1'b1, 6);

        // Stalls and length clamp
        send(32'hDDCCBBAA, 3'd7, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 3);

        // Abort after two chunks
        send(32'h87654321, 3'd0, 1'b0);
        idle(1'b1, 2);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b0, 1);
        send(32'h000000FF, 3'd0, 1'b1);
        idle(1'b1, 6);

        // Reset mid-word, then a fresh word
        send(32'h5A5B5C5D, 3'd0, 1'b1);
        idle(1'b1, 1);
        step(1'b1, 32'h11112222, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(32'hCAFEF00D, 3'd3, 1'b1);
        idle(1'b1, 5);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7),
                 $urandom,
                 CW'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 199) != 0));
        end
        idle(1'b1, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_stream_serializer.md
Name: piso_stream_serializer

Overview:
- Parametrised successor to the team's load/shift PISO shifter.
- Accepts a parallel word over a valid/ready handshake, with a per-word chunk count and a frame tag.
- Emits the word as SHIFT_AMOUNT-bit chunks over a valid/ready handshake, with per-word and per-frame last flags.
- Sits between the ChaCha20 keystream/ciphertext block output (16x32 bits) and narrow byte-stream sinks; supports back-to-back words with no bubble and truncated final blocks.

Parameters:
- PARALLEL_DATA_BITS, 512, width of the parallel input word; must be an integer multiple of SHIFT_AMOUNT.
- SHIFT_AMOUNT, 8, width of each serial output chunk.
- DIRECTION, "RIGHT", "RIGHT" emits from bit 0 upward; "LEFT" emits from the MSB downward.
- NUM_CHUNKS, PARALLEL_DATA_BITS/SHIFT_AMOUNT, derived; do not override.
- CNT_W, $clog2(NUM_CHUNKS+1), derived; width of the length and count fields.

Ports:
- clk_i  in  1  clock, all logic on the rising edge.
- rst_ni  in  1  synchronous reset, active low.
- s_valid_i  in  1  input word valid.
- s_ready_o  out  1  input word ready.
- s_data_i  in  PARALLEL_DATA_BITS  parallel word.
- s_len_i  in  CNT_W  number of chunks to emit: 0 = NUM_CHUNKS, >NUM_CHUNKS clamped to NUM_CHUNKS.
- s_last_i  in  1  word is the final word of a frame.
- abort_i  in  1  synchronous discard of the word in flight.
- m_valid_o  out  1  output chunk valid.
- m_ready_i  in  1  output chunk ready.
- m_data_o  out  SHIFT_AMOUNT  current chunk.
- m_last_o  out  1  current chunk is the last of its word.
- m_frame_last_o  out  1  m_last_o AND the word carried s_last_i.
- busy_o  out  1  a word is held (equals m_valid_o).

Behaviour:
- State: shift register sr_q (PARALLEL_DATA_BITS), remaining count rem_q (CNT_W), frame flag flast_q, valid flag vld_q.
- Two states: IDLE (vld_q=0), ACTIVE (vld_q=1).
- Reset (rst_ni=0 at a clock edge):
  - sr_q=0, rem_q=0, flast_q=0, vld_q=0.
  - Hence m_valid_o=0, m_data_o=0, m_last_o=0, m_frame_last_o=0, busy_o=0.
  - Reset mid-word discards the word with no further output.
- Output mapping:
  - m_data_o = sr_q[0 +: SHIFT_AMOUNT] for RIGHT, sr_q[PARALLEL_DATA_BITS-1 -: SHIFT_AMOUNT] for LEFT; driven directly from registers.
  - m_valid_o = vld_q.
  - m_last_o = vld_q & (rem_q==1).
  - m_frame_last_o = m_last_o & flast_q.
- Handshakes:
  - out_fire = m_valid_o & m_ready_i.
  - s_ready_o = ~vld_q | (out_fire & m_last_o). This is combinational from m_ready_i, so back-to-back words have zero-cycle gaps.
  - in_fire = s_valid_i & s_ready_o.
- Accept (in_fire):
  - sr_q <= s_data_i, rem_q <= clamped/decoded s_len_i, flast_q <= s_last_i, vld_q <= 1.
  - First chunk appears on m_data_o the cycle after acceptance (latency 1).
- Shift (out_fire & ~m_last_o): sr_q shifts by SHIFT_AMOUNT toward the emit end, zero-filled; rem_q decrements.
- Word end (out_fire & m_last_o & ~in_fire): vld_q <= 0, rem_q <= 0; sr_q holds its value.
- Word end with simultaneous accept: the new word loads. Accept has priority over shift.
- Stall (m_valid_o & ~m_ready_i): all registers hold and m_data_o is stable. m_valid_o must not drop without out_fire, except on abort or reset.
- abort_i:
  - Forces vld_q <= 0, rem_q <= 0, and s_ready_o=0 in that cycle, so no accept occurs.
  - Priority, highest first: reset, abort, accept, shift.
  - Abort in IDLE has no effect.
- Chunks beyond the decoded length are never emitted.
- s_data_i, s_len_i and s_last_i are sampled only on in_fire.

Test Plan (PARALLEL_DATA_BITS=32, SHIFT_AMOUNT=8 unless stated):
1. RIGHT, s_data_i=0x44332211, s_len_i=0, s_last_i=1, m_ready_i=1 -> accept at cycle 0. Cycles 1..4 emit 0x11, 0x22, 0x33, 0x44. m_last_o and m_frame_last_o are high only with 0x44. Cycle 5: m_valid_o=0.
2. LEFT, same word, s_len_i=2 -> emits 0x44 then 0x33. m_last_o is high on 0x33, then idle.
3. Two words back-to-back (0xA3A2A1A0 then 0xB3B2B1B0, s_valid_i held high) -> 8 contiguous m_valid_o cycles A0..A3, B0..B3. s_ready_o is high in the cycle A3 fires.
4. m_ready_i toggled 1,0,0,1,1,0,1 during 0xDDCCBBAA -> every chunk emitted exactly once, in order; m_data_o stable while stalled. s_len_i=7 is clamped and yields exactly 4 chunks.
5. abort_i pulsed after 2 chunks of 0x87654321 -> next cycle m_valid_o=0 and s_ready_o=1. A following word 0x000000FF emits 0xFF first.
6. rst_ni low mid-word, then s_valid_i asserted -> all outputs 0 after the reset edge. The next word is accepted and serialised cleanly.
